// File: rtl/debug_frame_sender.sv
// Debug return path: snapshots NUM_WORDS words on start and sends HEADER, payload (MSB byte first), XOR checksum over UART.
// Latency start->tx_start 2 cycles, tx_done_tick->tx_start 1 cycle; paced by tx_done_tick, start ignored while busy or in FIN.
module debug_frame_sender #(
    parameter int                       NBIT_DATA_LEN = 8,
    parameter int                       len_data      = 32,
    parameter int                       NUM_WORDS     = 4,
    parameter logic [NBIT_DATA_LEN-1:0] HEADER        = 'hA5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_WORDS*len_data-1:0]   words_in,
    input  logic                            tx_done_tick,
    output logic                            tx_start,
    output logic [NBIT_DATA_LEN-1:0]        data_out,
    output logic                            busy,
    output logic                            done
);
    localparam int NB  = NBIT_DATA_LEN;
    localparam int BPW = len_data / NBIT_DATA_LEN;
    localparam int TOT = NUM_WORDS * len_data;
    localparam int WW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;
    typedef enum logic [1:0] {K_HDR, K_PAY, K_CHK} kind_t;

    state_t          state_q, state_d;
    kind_t           kind_q, kind_d;
    logic [WW-1:0]   word_q, word_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [NB-1:0]   chk_q, chk_d;
    logic [TOT-1:0]  snap_q, snap_d;
    logic            tx_start_q, tx_start_d;
    logic [NB-1:0]   data_out_q, data_out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Snapshot is stored word 0 at the top so the next payload byte is always the top byte; it shifts left per byte.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        word_d     = word_q;
        byte_d     = byte_q;
        chk_d      = chk_q;
        snap_d     = snap_q;
        tx_start_d = 1'b0;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        snap_d[(NUM_WORDS-1-k)*len_data +: len_data] = words_in[k*len_data +: len_data];
                    end
                    chk_d   = '0;
                    word_d  = '0;
                    byte_d  = '0;
                    kind_d  = K_HDR;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_start_d = 1'b1;
                data_out_d = HEADER;
                state_d    = WAIT;
            end
            WAIT: begin
                // Later bytes launch straight from WAIT so the next tx_start follows tx_done_tick by one cycle.
                if (tx_done_tick && !tx_start_q) begin
                    case (kind_q)
                        K_HDR: begin
                            kind_d     = K_PAY;
                            tx_start_d = 1'b1;
                            data_out_d = snap_q[TOT-1 -: NB];
                        end
                        K_PAY: begin
                            chk_d      = chk_q ^ data_out_q;
                            tx_start_d = 1'b1;
                            if (byte_q == BW'(BPW-1) && word_q == WW'(NUM_WORDS-1)) begin
                                kind_d     = K_CHK;
                                data_out_d = chk_d;
                            end else begin
                                if (byte_q == BW'(BPW-1)) begin
                                    byte_d = '0;
                                    word_d = word_q + WW'(1);
                                end else begin
                                    byte_d = byte_q + BW'(1);
                                end
                                snap_d     = snap_q << NB;
                                data_out_d = snap_d[TOT-1 -: NB];
                            end
                        end
                        default: begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = FIN;
                        end
                    endcase
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            kind_q     <= K_HDR;
            word_q     <= '0;
            byte_q     <= '0;
            chk_q      <= '0;
            snap_q     <= '0;
            tx_start_q <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            chk_q      <= chk_d;
            snap_q     <= snap_d;
            tx_start_q <= tx_start_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_start = tx_start_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule
